// File: rtl/banco_reg_pkg.sv
// Shared types and helpers for the parameterised register bank.
package banco_reg_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } clr_state_t;

    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

endpackage

// File: rtl/banco_reg_clr_seq.sv
// Sequential clear controller: walks every register index once after clr_req.
module banco_reg_clr_seq
    import banco_reg_pkg::*;
#(
    parameter int N_REGS = 16,
    parameter int ADDR_W = clog2(N_REGS)
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [ADDR_W-1:0] clr_idx
);

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_REGS - 1);

    clr_state_t        state;
    clr_state_t        state_nxt;
    logic [ADDR_W-1:0] idx;
    logic [ADDR_W-1:0] idx_nxt;

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        idx_nxt   = idx;
        unique case (state)
            IDLE: begin
                if (clr_req) begin
                    state_nxt = CLEAR;
                    idx_nxt   = '0;
                end
            end
            CLEAR: begin
                if (idx == LAST_IDX) begin
                    state_nxt = IDLE;
                    idx_nxt   = '0;
                end else begin
                    idx_nxt = idx + 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
                idx_nxt   = '0;
            end
        endcase
    end

    assign clr_busy = (state == CLEAR);
    assign clr_idx  = idx;

endmodule

// File: rtl/banco_reg_param.sv
// Register bank with two bypassed read ports, load scoreboard and sequential clear.
module banco_reg_param
    import banco_reg_pkg::*;
#(
    parameter int DATA_W   = 8,
    parameter int N_REGS   = 16,
    parameter int ADDR_W   = clog2(N_REGS),
    parameter int A0_IDX   = 7,
    parameter int ZERO_REG = 0
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    output logic              rd_busy1,
    output logic              rd_busy2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              busy_set,
    input  logic [ADDR_W-1:0] busy_addr,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic [DATA_W-1:0] a0_data
);

    logic [DATA_W-1:0] regs [N_REGS];
    logic [N_REGS-1:0] busy;
    logic [ADDR_W-1:0] clr_idx;
    logic              wr_ok;
    logic              set_ok;

    // Index is usable: in range and not the hardwired zero register.
    function automatic logic live(input logic [ADDR_W-1:0] addr);
        return (int'(addr) < N_REGS) && !((ZERO_REG != 0) && (addr == '0));
    endfunction

    banco_reg_clr_seq #(
        .N_REGS (N_REGS),
        .ADDR_W (ADDR_W)
    ) u_clr_seq (
        .clock    (clock),
        .reset    (reset),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_idx  (clr_idx)
    );

    assign wr_ok  = wr_en && !clr_busy && live(wr_addr);
    assign set_ok = busy_set && !clr_busy && live(busy_addr);

    // Busy set is applied after the write clear so it wins on a collision.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < N_REGS; i++) begin
                regs[i] <= '0;
            end
            busy <= '0;
        end else if (clr_busy) begin
            regs[clr_idx] <= '0;
            busy[clr_idx] <= 1'b0;
        end else begin
            if (wr_ok) begin
                regs[wr_addr] <= wr_data;
                busy[wr_addr] <= 1'b0;
            end
            if (set_ok) begin
                busy[busy_addr] <= 1'b1;
            end
        end
    end

    always_comb begin
        rd_data1 = '0;
        rd_busy1 = 1'b0;
        if (live(rd_addr1)) begin
            rd_data1 = (wr_ok && wr_addr == rd_addr1) ? wr_data : regs[rd_addr1];
            rd_busy1 = busy[rd_addr1] && !(wr_ok && wr_addr == rd_addr1);
        end
    end

    always_comb begin
        rd_data2 = '0;
        rd_busy2 = 1'b0;
        if (live(rd_addr2)) begin
            rd_data2 = (wr_ok && wr_addr == rd_addr2) ? wr_data : regs[rd_addr2];
            rd_busy2 = busy[rd_addr2] && !(wr_ok && wr_addr == rd_addr2);
        end
    end

    assign a0_data = regs[A0_IDX];

endmodule

// File: tb/tb_banco_reg_param.sv
// Directed bench for banco_reg_param built with the zero register enabled.
module tb_banco_reg_param;

    localparam int DW = 8;
    localparam int NR = 16;
    localparam int AW = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic [AW-1:0] rd_addr1, rd_addr2, wr_addr, busy_addr;
    logic [DW-1:0] rd_data1, rd_data2, wr_data, a0_data;
    logic          rd_busy1, rd_busy2, wr_en, busy_set, clr_req, clr_busy;

    int n_chk = 0;
    int n_fail = 0;

    banco_reg_param #(
        .DATA_W   (DW),
        .N_REGS   (NR),
        .ADDR_W   (AW),
        .A0_IDX   (7),
        .ZERO_REG (1)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .rd_addr1  (rd_addr1),
        .rd_addr2  (rd_addr2),
        .rd_data1  (rd_data1),
        .rd_data2  (rd_data2),
        .rd_busy1  (rd_busy1),
        .rd_busy2  (rd_busy2),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .busy_set  (busy_set),
        .busy_addr (busy_addr),
        .clr_req   (clr_req),
        .clr_busy  (clr_busy),
        .a0_data   (a0_data)
    );

    always #5 clock = ~clock;

    typedef struct {
        string         name;
        logic          we;
        logic [AW-1:0] wa;
        logic [DW-1:0] wd;
        logic          bs;
        logic [AW-1:0] ba;
        logic [AW-1:0] ra1;
        logic [AW-1:0] ra2;
        logic [DW-1:0] d1;
        logic [DW-1:0] d2;
        logic          b1;
        logic          b2;
        logic [DW-1:0] a0;
    } vec_t;

    vec_t vecs [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_in;
        wr_en = 0; wr_addr = 0; wr_data = 0;
        busy_set = 0; busy_addr = 0; clr_req = 0;
    endtask

    task automatic fill_aa;
        for (int i = 0; i < NR; i++) begin
            wr_en = 1; wr_addr = AW'(i); wr_data = 8'hAA;
            step();
        end
        idle_in();
    endtask

    initial begin
        int n;
        vecs[0]  = '{"byp3",    1, 3, 8'h5A, 0, 0, 3, 3, 8'h5A, 8'h5A, 0, 0, 8'h00};
        vecs[1]  = '{"rd3",     0, 0, 8'h00, 0, 0, 3, 3, 8'h5A, 8'h5A, 0, 0, 8'h00};
        vecs[2]  = '{"byp4",    1, 4, 8'h33, 0, 0, 4, 3, 8'h33, 8'h5A, 0, 0, 8'h00};
        vecs[3]  = '{"bset5",   0, 0, 8'h00, 1, 5, 5, 4, 8'h00, 8'h33, 0, 0, 8'h00};
        vecs[4]  = '{"busy5",   0, 0, 8'h00, 0, 0, 5, 3, 8'h00, 8'h5A, 1, 0, 8'h00};
        vecs[5]  = '{"wr5",     1, 5, 8'h11, 0, 0, 5, 5, 8'h11, 8'h11, 0, 0, 8'h00};
        vecs[6]  = '{"clr5",    0, 0, 8'h00, 0, 0, 5, 5, 8'h11, 8'h11, 0, 0, 8'h00};
        vecs[7]  = '{"both5",   1, 5, 8'h22, 1, 5, 5, 5, 8'h22, 8'h22, 0, 0, 8'h00};
        vecs[8]  = '{"setwins", 0, 0, 8'h00, 0, 0, 5, 5, 8'h22, 8'h22, 1, 1, 8'h00};
        vecs[9]  = '{"z0wr",    1, 0, 8'hFF, 1, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        vecs[10] = '{"z0rd",    0, 0, 8'h00, 0, 0, 0, 0, 8'h00, 8'h00, 0, 0, 8'h00};
        vecs[11] = '{"wr7",     1, 7, 8'hC3, 0, 0, 7, 3, 8'hC3, 8'h5A, 0, 0, 8'h00};
        vecs[12] = '{"a0",      0, 0, 8'h00, 0, 0, 7, 2, 8'hC3, 8'h00, 0, 0, 8'hC3};

        // Reset priority over a simultaneous write, busy_set and clr_req.
        idle_in();
        rd_addr1 = 7; rd_addr2 = 7;
        reset = 1;
        step();
        reset = 0;
        wr_en = 1; wr_addr = 7; wr_data = 8'h99; busy_set = 1; busy_addr = 7;
        step();
        reset = 1; wr_data = 8'h44; clr_req = 1;
        step();
        reset = 0;
        idle_in();
        #1;
        chk("rst_a0", a0_data, 0);
        chk("rst_d1", rd_data1, 0);
        chk("rst_b1", rd_busy1, 0);
        chk("rst_clr", clr_busy, 0);

        foreach (vecs[i]) begin
            wr_en = vecs[i].we; wr_addr = vecs[i].wa; wr_data = vecs[i].wd;
            busy_set = vecs[i].bs; busy_addr = vecs[i].ba;
            rd_addr1 = vecs[i].ra1; rd_addr2 = vecs[i].ra2;
            #1;
            chk({vecs[i].name, "_d1"}, rd_data1, vecs[i].d1);
            chk({vecs[i].name, "_d2"}, rd_data2, vecs[i].d2);
            chk({vecs[i].name, "_b1"}, rd_busy1, vecs[i].b1);
            chk({vecs[i].name, "_b2"}, rd_busy2, vecs[i].b2);
            chk({vecs[i].name, "_a0"}, a0_data, vecs[i].a0);
            step();
        end
        idle_in();

        // Full clear with a write to reg 10 attempted mid-sequence.
        fill_aa();
        #1;
        chk("fill_a0", a0_data, 8'hAA);
        clr_req = 1;
        step();
        clr_req = 0;
        n = 0;
        while (clr_busy === 1'b1 && n < 100) begin
            n++;
            if (n == 4) begin
                wr_en = 1; wr_addr = 10; wr_data = 8'h55; rd_addr1 = 10;
                #1;
                chk("clr_nobyp", rd_data1, 8'hAA);
            end else if (n == 5) begin
                idle_in();
                #1;
                chk("clr_drop", rd_data1, 8'hAA);
            end
            step();
        end
        chk("clr_cycles", n, NR);
        chk("clr_done", clr_busy, 0);
        for (int i = 0; i < NR; i++) begin
            rd_addr1 = AW'(i); rd_addr2 = AW'(NR - 1 - i);
            #1;
            chk("clr_reg", rd_data1, 0);
        end
        chk("clr_a0", a0_data, 0);

        // Reset at CLEAR cycle 6 aborts the sequence.
        fill_aa();
        clr_req = 1;
        step();
        clr_req = 0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_busy", clr_busy, 1);
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("abort_busy", clr_busy, 0);
        for (int i = 0; i < NR; i++) begin
            rd_addr1 = AW'(i); rd_addr2 = AW'(i);
            #1;
            chk("abort_reg", rd_data2, 0);
        end
        chk("abort_a0", a0_data, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/banco_reg_param.md
BANCO_REG_PARAM -- requirements
Module: banco_reg_param

Interface
REQ-001 The block SHALL have these parameters (name, default, meaning):
- DATA_W, 8, register width in bits.
- N_REGS, 16, number of registers (2..256).
- ADDR_W, clog2(N_REGS), index width (derived).
- A0_IDX, 7, index driven on the dedicated a0 output.
- ZERO_REG, 0, if 1 register 0 reads as zero and ignores writes.

REQ-002 The block SHALL have these ports (name, direction, width, meaning):
- clock, in, 1, single clock; all state on rising edge.
- reset, in, 1, synchronous, active-high.
- rd_addr1, in, ADDR_W, read port 1 index.
- rd_addr2, in, ADDR_W, read port 2 index.
- rd_data1, out, DATA_W, read port 1 data.
- rd_data2, out, DATA_W, read port 2 data.
- rd_busy1, out, 1, port 1 register has a pending write.
- rd_busy2, out, 1, port 2 register has a pending write.
- wr_en, in, 1, write strobe.
- wr_addr, in, ADDR_W, write index.
- wr_data, in, DATA_W, write data.
- busy_set, in, 1, mark busy_addr as pending (load issued).
- busy_addr, in, ADDR_W, index to mark pending.
- clr_req, in, 1, start a sequential clear of all registers.
- clr_busy, out, 1, clear sequence in progress.
- a0_data, out, DATA_W, contents of register A0_IDX (no bypass).

REQ-003 There SHALL be one clock, clock; reset SHALL be synchronous and active-high, named reset.

Function
REQ-004 Reads SHALL be combinational, with zero-cycle latency.
REQ-005 When wr_en=1, clr_busy=0 and wr_addr equals a read address, that port SHALL return wr_data (bypass).
REQ-006 A write SHALL update the register on the rising edge when wr_en=1 and clr_busy=0.
REQ-007 With ZERO_REG=1, index 0 SHALL read 0, SHALL not be bypassed, SHALL ignore writes, and SHALL never be busy.
REQ-008 An index >= N_REGS SHALL read 0 and SHALL have its writes and busy_set ignored.
REQ-009 Scoreboard: busy_set SHALL set busy[busy_addr] on the edge; a write SHALL clear busy[wr_addr].
REQ-010 When busy_set and a write target the same index in the same cycle, the set SHALL win.
REQ-011 rd_busyN SHALL equal busy[rd_addrN] AND NOT (wr_en and wr_addr=rd_addrN and clr_busy=0).
REQ-012 The clear FSM SHALL have two states:
- IDLE: clr_req=1 moves to CLEAR with idx=0.
- CLEAR: each cycle writes 0 to reg[idx] and clears busy[idx], then increments idx.
- At idx=N_REGS-1 it returns to IDLE, so a clear takes exactly N_REGS cycles.
REQ-013 clr_busy SHALL be 1 exactly while in CLEAR.
REQ-014 During CLEAR, wr_en, busy_set and clr_req SHALL be ignored, and reads SHALL return array contents without bypass.

Reset
REQ-015 Reset SHALL apply the following on the edge:
- All registers and all busy bits go to 0.
- The FSM goes to IDLE with idx=0.
- rd_data*, a0_data, rd_busy* and clr_busy go to 0.
REQ-016 Reset asserted mid-CLEAR SHALL abort the sequence immediately.
REQ-017 Reset SHALL have priority over wr_en, busy_set and clr_req.

Structure
REQ-018 A shared package SHALL hold the FSM state enum (IDLE, CLEAR) and the clog2 helper.
REQ-019 The clear FSM and idx counter SHALL be a sub-module, banco_reg_clr_seq.

Verification
REQ-020 Write x5A to reg 3, then read reg 3 on both ports next cycle: rd_data1 = rd_data2 = x5A.
REQ-021 Apply wr_en=1, wr_addr=4, wr_data=x33, with rd_addr1=4 in the same cycle: rd_data1 = x33 before the edge.
REQ-022 busy_set on reg 5, then reading reg 5 gives rd_busy1=1; a write x11 to reg 5 gives rd_busy1=0 combinationally and busy cleared after the edge. busy_set and a write to reg 5 in the same cycle leave busy=1.
REQ-023 With ZERO_REG=1, write xFF to reg 0: reads return x00 and rd_busy=0.
REQ-024 After filling regs with xAA, pulse clr_req: clr_busy stays high 16 cycles, a write during CLEAR is dropped, and afterwards all regs and a0_data read x00.
REQ-025 Assert reset at CLEAR cycle 6: next cycle clr_busy=0 and all regs are 0.
